// File: rtl/io_sequencer.sv
// io_sequencer: loads a memory image from RX, lets the CPU run on it, then dumps a memory window to TX
module io_sequencer #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 16,
  parameter int LOAD_LEN    = 256,
  parameter int DUMP_BASE   = 0,
  parameter int DUMP_LEN    = 256,
  parameter int RUN_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_enable,
  input  logic              cpu_finish,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              sel_cpu,
  output logic              timeout,
  output logic              done
);
  localparam int LW = LOAD_LEN > 1 ? $clog2(LOAD_LEN + 1) : 1;
  localparam int DW = DUMP_LEN > 1 ? $clog2(DUMP_LEN + 1) : 1;
  localparam int RW = RUN_TIMEOUT > 1 ? $clog2(RUN_TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP_RD, DUMP_CAP, DUMP_TX, DUMP_WAIT, DONE} state_t;
  state_t state;
  logic [LW-1:0] load_cnt;
  logic [DW-1:0] dump_cnt;
  logic [RW-1:0] run_cnt;
  logic [DATA_W-1:0] rx_buf;
  logic wr_pend;
  logic run_limit;
  logic [ADDR_W-1:0] dump_addr;
  // the limit hits on the last allowed RUN cycle so RUN lasts exactly RUN_TIMEOUT cycles
  assign run_limit = RUN_TIMEOUT != 0 && run_cnt == RW'(RUN_TIMEOUT - 1);
  assign dump_addr = ADDR_W'(DUMP_BASE) + ADDR_W'(dump_cnt);
  assign busy = state != IDLE;
  assign cpu_rdata = sel_cpu ? mem_rdata : '0;
  // memory port mux: CPU owns it in RUN, the loader in LOAD, the dumper reads in DUMP_RD/CAP
  always_comb begin
    mem_we = state == RUN ? cpu_we : state == LOAD && wr_pend;
    mem_wdata = state == RUN ? cpu_wdata : state == LOAD ? rx_buf : '0;
    mem_addr = state == RUN ? cpu_addr : state == LOAD ? ADDR_W'(load_cnt) : (state == DUMP_RD || state == DUMP_CAP) ? dump_addr : '0;
  end
  // session sequencer with registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      load_cnt <= '0;
      dump_cnt <= '0;
      run_cnt <= '0;
      rx_buf <= '0;
      wr_pend <= 1'b0;
      tx_data <= '0;
      tx_start <= 1'b0;
      cpu_enable <= 1'b0;
      sel_cpu <= 1'b0;
      timeout <= 1'b0;
      done <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          timeout <= 1'b0;
          load_cnt <= '0;
          dump_cnt <= '0;
          run_cnt <= '0;
          wr_pend <= 1'b0;
          state <= LOAD_LEN > 0 ? LOAD : RUN;
          cpu_enable <= LOAD_LEN == 0;
          sel_cpu <= LOAD_LEN == 0;
        end
        LOAD: begin
          if (rx_done) rx_buf <= rx_data;
          wr_pend <= rx_done;
          if (wr_pend) begin
            load_cnt <= load_cnt + LW'(1);
            if (load_cnt == LW'(LOAD_LEN - 1)) begin
              state <= RUN;
              cpu_enable <= 1'b1;
              sel_cpu <= 1'b1;
              wr_pend <= 1'b0;
            end
          end
        end
        RUN: begin
          run_cnt <= run_cnt + RW'(1);
          if (cpu_finish || run_limit) begin
            timeout <= !cpu_finish;
            state <= DUMP_LEN > 0 ? DUMP_RD : DONE;
            done <= DUMP_LEN == 0;
            cpu_enable <= 1'b0;
            sel_cpu <= 1'b0;
          end
        end
        DUMP_RD: state <= DUMP_CAP;
        DUMP_CAP: begin
          tx_data <= mem_rdata;
          tx_start <= 1'b1;
          state <= DUMP_TX;
        end
        DUMP_TX: state <= DUMP_WAIT;
        DUMP_WAIT: if (tx_done) begin
          dump_cnt <= dump_cnt + DW'(1);
          if (dump_cnt + DW'(1) == DW'(DUMP_LEN)) begin
            state <= DONE;
            done <= 1'b1;
          end else state <= DUMP_RD;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
